// File: rtl/flash_bus_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// flash_bus_pkg
// Shared definitions for the parallel NOR flash bus sequencer:
//   - state_e       : sequencer FSM states
//   - *_DEF         : default bus widths and strobe timing (in clk cycles)
//   - max3()        : constant helper used to size the wait counter
// -----------------------------------------------------------------------------
package flash_bus_pkg;

    localparam int ADDR_W_DEF  = 23;
    localparam int DATA_W_DEF  = 16;
    localparam int RD_WAIT_DEF = 4;
    localparam int WR_WAIT_DEF = 3;
    localparam int HOLD_DEF    = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RD_STROBE,
        WR_STROBE,
        RECOVER
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/flash_bus_sequencer_if.sv
// -----------------------------------------------------------------------------
// flash_bus_sequencer_if
// Bundles the two-port request handshake and the flash pin signals.
//   master : requester / board side (drives requests and flash_dq_i)
//   slave  : the sequencer (drives ready/done/rdata, pins, busy)
// Request fields: req_valid/req_wr/req_ready/req_done are 2-bit, bit n = port n.
// -----------------------------------------------------------------------------
interface flash_bus_sequencer_if
    import flash_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [1:0]        req_valid;
    logic [1:0]        req_wr;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        req_ready;
    logic [1:0]        req_done;
    logic [DATA_W-1:0] rdata;

    logic [ADDR_W-1:0] flash_a;
    logic [DATA_W-1:0] flash_dq_o;
    logic              flash_dq_oe;
    logic [DATA_W-1:0] flash_dq_i;
    logic              flash_cs_b;
    logic              flash_oe_b;
    logic              flash_we_b;
    logic              busy;

    modport master (
        output req_valid, req_wr, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output flash_dq_i,
        input  req_ready, req_done, rdata,
        input  flash_a, flash_dq_o, flash_dq_oe, flash_cs_b, flash_oe_b, flash_we_b,
        input  busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  flash_dq_i,
        output req_ready, req_done, rdata,
        output flash_a, flash_dq_o, flash_dq_oe, flash_cs_b, flash_oe_b, flash_we_b,
        output busy
    );

endinterface

// File: rtl/flash_bus_sequencer_arb.sv
// -----------------------------------------------------------------------------
// flash_rr_arbiter
// Two-port round-robin arbiter.
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : per-port requests
//   advance    : the current grant was taken; remember who won
//   grant[1:0] : one-hot grant (all-zero when nobody requests)
// The last-grant pointer resets to port 1 so port 0 wins the first tie.
// -----------------------------------------------------------------------------
module flash_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant  = req;
        last_d = last_q;
        // Tie: favour the port that did not win last time.
        if (req == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
        if (advance) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/flash_bus_sequencer.sv
// -----------------------------------------------------------------------------
// flash_bus_sequencer
// Shares a parallel NOR flash bus between two requesters (port 0: boot-time
// parameter reader, port 1: slow-control command path) and runs every access
// as a timed CS/OE/WE cycle: IDLE -> SETUP -> RD/WR_STROBE -> RECOVER -> IDLE.
//   clk, reset : clock and synchronous active-high reset
//   bus        : request handshake + flash pins (slave side)
// Parameters: RD_WAIT = OE low cycles, WR_WAIT = WE low cycles,
//             HOLD = CS-high recovery cycles between accesses (all >= 1).
// All pin outputs are registered so the strobes are glitch-free.
// -----------------------------------------------------------------------------
module flash_bus_sequencer
    import flash_bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int WR_WAIT = WR_WAIT_DEF,
    parameter int HOLD    = HOLD_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    flash_bus_sequencer_if.slave bus
);

    localparam int MAX_WAIT = max3(RD_WAIT, WR_WAIT, HOLD);
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    // Counter holds "cycles remaining after this one", so N-cycle states load N-1.
    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_WAIT - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wr_q, wr_d;
    logic [1:0]        grant_q, grant_d;
    logic [1:0]        done_q, done_d;
    logic              cs_b_q, cs_b_d;
    logic              oe_b_q, oe_b_d;
    logic              we_b_q, we_b_d;
    logic              dq_oe_q, dq_oe_d;

    logic [1:0]        grant;
    logic              accept;

    logic [ADDR_W-1:0] port_addr  [2];
    logic [DATA_W-1:0] port_wdata [2];

    assign port_addr[0]  = bus.req_addr0;
    assign port_addr[1]  = bus.req_addr1;
    assign port_wdata[0] = bus.req_wdata0;
    assign port_wdata[1] = bus.req_wdata1;

    flash_rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.req_valid),
        .advance (accept),
        .grant   (grant)
    );

    // Ready is only the combinational accept qualified per port.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign bus.req_ready[gi] = accept & grant[gi];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        grant_d = grant_q;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!reset && (grant != 2'b00)) begin
                    accept  = 1'b1;
                    grant_d = grant;
                    addr_d  = grant[1] ? port_addr[1]  : port_addr[0];
                    wdata_d = grant[1] ? port_wdata[1] : port_wdata[0];
                    wr_d    = |(bus.req_wr & grant);
                    state_d = SETUP;
                    cnt_d   = '0;
                end
            end
            SETUP: begin
                state_d = wr_q ? WR_STROBE : RD_STROBE;
                cnt_d   = wr_q ? WR_LOAD : RD_LOAD;
            end
            RD_STROBE: begin
                if (cnt_q == '0) begin
                    // Capture on the last OE-low cycle: data has had RD_WAIT cycles to settle.
                    rdata_d = bus.flash_dq_i;
                    state_d = RECOVER;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WR_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = RECOVER;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pins are decoded from the next state and registered, so they line up
        // with state_q in the following cycle.
        cs_b_d  = !((state_d == SETUP) || (state_d == RD_STROBE) || (state_d == WR_STROBE));
        oe_b_d  = (state_d != RD_STROBE);
        we_b_d  = (state_d != WR_STROBE);
        // Keep driving DQ through the first RECOVER cycle as data hold after WE rises.
        dq_oe_d = wr_d && ((state_d == SETUP) || (state_d == WR_STROBE) ||
                           ((state_d == RECOVER) && (state_q == WR_STROBE)));
        done_d  = ((state_d == RECOVER) && (state_q != RECOVER)) ? grant_q : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
            cs_b_q  <= 1'b1;
            oe_b_q  <= 1'b1;
            we_b_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            cs_b_q  <= cs_b_d;
            oe_b_q  <= oe_b_d;
            we_b_q  <= we_b_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    assign bus.req_done    = done_q;
    assign bus.rdata       = rdata_q;
    assign bus.flash_a     = addr_q;
    assign bus.flash_dq_o  = wdata_q;
    assign bus.flash_dq_oe = dq_oe_q;
    assign bus.flash_cs_b  = cs_b_q;
    assign bus.flash_oe_b  = oe_b_q;
    assign bus.flash_we_b  = we_b_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/flash_bus_sequencer.md
# flash_bus_sequencer

Shares the board's parallel NOR flash bus between two requesters and sequences every flash access as a timed chip-select/output-enable/write-enable cycle. Port 0 is the boot-time parameter reader that fetches IP and serial number. Port 1 is the slow-control flash command path fed from UDP. The block sits between those requesters and the FLASH_A/FLASH_DQ/FLASH_CS_B/FLASH_OE_B/FLASH_WE_B pins, in the SlowClk domain.

## Interface
Parameters:
- ADDR_W, 23, flash word-address width
- DATA_W, 16, flash data width
- RD_WAIT, 4, cycles OE_B held low before data capture (≥1)
- WR_WAIT, 3, WE_B low pulse width in cycles (≥1)
- HOLD, 2, recovery cycles with CS_B high between accesses (≥1)

Ports:
- clk  in  1  block clock (SlowClk); the block uses only this clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-port access request; bit n = port n
- req_wr  in  2  1 = write, 0 = read
- req_addr0, req_addr1  in  ADDR_W  word address
- req_wdata0, req_wdata1  in  DATA_W  write data
- req_ready  out  2  request accepted this cycle
- req_done  out  2  one-cycle completion pulse
- rdata  out  DATA_W  last read word; shared by both ports
- flash_a  out  ADDR_W  address pins
- flash_dq_o  out  DATA_W  data to pins
- flash_dq_oe  out  1  tristate enable for flash_dq_o
- flash_dq_i  in  DATA_W  data from pins
- flash_cs_b, flash_oe_b, flash_we_b  out  1  active-low strobes
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE → SETUP → RD_STROBE or WR_STROBE → RECOVER → IDLE.
- IDLE:
  - If any req_valid is high, the arbiter grants one port.
  - req_ready[g] = 1 combinationally in that cycle.
  - addr, wdata and the wr flag of the granted port are latched, and the FSM moves to SETUP.
- Arbitration: two-way round-robin.
  - The last-granted pointer resets to 1, so port 0 wins the first tie.
  - On simultaneous requests, the port not granted last wins.
  - A lone requester always wins.
  - req_valid must stay high until ready; dropping it earlier withdraws the request.
- SETUP (1 cycle): flash_a driven, cs_b = 0, oe_b = we_b = 1. For writes, dq_o = wdata and dq_oe = 1.
- RD_STROBE (RD_WAIT cycles): oe_b = 0. flash_dq_i is registered into rdata on the last cycle.
- WR_STROBE (WR_WAIT cycles): we_b = 0 and dq_oe = 1.
- RECOVER (HOLD cycles):
  - cs_b = oe_b = we_b = 1.
  - For writes, dq_oe stays 1 during the first RECOVER cycle only (data hold).
  - flash_a is held until IDLE.
  - req_done[g] pulses in the first RECOVER cycle.
- rdata holds its value until the next read completes; writes do not alter it.
- Wait counter width: $clog2(max(RD_WAIT, WR_WAIT, HOLD) + 1). The counter reloads on every state entry.

## Timing
- Reset values: cs_b = oe_b = we_b = 1; dq_oe = 0; flash_a = 0; dq_o = 0; rdata = 0; req_ready = req_done = 0; busy = 0; FSM in IDLE.
- Read, accepted at cycle 0:
  - SETUP at cycle 1.
  - oe_b low in cycles 2..RD_WAIT+1.
  - req_done and valid rdata at cycle RD_WAIT+2.
  - Defaults: done at cycle 6.
- Write, accepted at cycle 0:
  - we_b low in cycles 2..WR_WAIT+1.
  - done at cycle WR_WAIT+2 (default 5).
  - dq_oe high in cycles 1..WR_WAIT+2.
- Back-to-back: IDLE is re-entered at done + HOLD, so the next accept comes no earlier than that cycle.
  - Default read-to-read period is RD_WAIT + HOLD + 2 = 8 cycles.
- At most one req_ready and at most one req_done bit is high in any cycle. Ready is never asserted outside IDLE.
- Reset asserted mid-access: on the next edge all strobes return to their reset values. No req_done is issued and the access is lost.
- oe_b and we_b are never low simultaneously. Neither is low while cs_b is high.

## Structure
- Package flash_bus_pkg holds:
  - the state enum (IDLE, SETUP, RD_STROBE, WR_STROBE, RECOVER)
  - default timing constants
  - the ADDR_W and DATA_W defaults
- Sub-module flash_rr_arbiter contains the two-port round-robin grant logic with the last-grant pointer. It takes req[1:0] and an advance input, and outputs a one-hot grant.
- The FSM, wait counter, latches and pin drivers live in flash_bus_sequencer.

## Test plan
- Single read: port 1 reads addr 0x000010 while the model returns 0xBEEF.
  - Expect oe_b low exactly in cycles 2–5.
  - Expect req_done = 2'b10 and rdata = 0xBEEF at cycle 6.
- Single write: port 0 writes 0x1234 to 0x7FFFFF.
  - Expect we_b low in cycles 2–4 and dq_oe high in cycles 1–5.
  - Expect done at cycle 5; rdata remains unchanged.
- Contention: both ports hold req_valid high for 4 accesses.
  - Expect grant order 0, 1, 0, 1.
  - Expect an 8-cycle spacing between consecutive ready pulses.
- Mid-access reset: assert reset at cycle 3 of a read.
  - Expect all strobes inactive and dq_oe = 0 the next cycle, and no done.
  - Expect a fresh port-0 request afterwards to complete normally.
- Parameter sweep: RD_WAIT = 1, WR_WAIT = 1, HOLD = 1.
  - Expect read done at cycle 3 and write done at cycle 3.
  - Expect the next accept 1 cycle after done.
  - Throughout, assertions check that oe_b and we_b are never both low.
